// File: rtl/ip_hdr_sched.sv
// Shared serial UDP/IPv4 header builder: round-robin grant over NREQ lanes,
// ones-complement checksum one word per cycle, valid/ready header output.

module ip_hdr_sched_lane #(
  parameter logic [15:0] MIN_FRAME = 16'd38
) (
  input  logic [15:0] frame_len,
  output logic        short_len,
  output logic [15:0] tot_len
);
  // Ethernet header (14) and FCS (4) are not part of the IP datagram.
  assign short_len = (frame_len < MIN_FRAME);
  assign tot_len   = frame_len - 16'd18;
endmodule

module ip_hdr_sched #(
  parameter int          NREQ      = 4,
  parameter logic [31:0] SADDR     = 32'hC0A80165,
  parameter logic [31:0] DADDR     = 32'hC0A80266,
  parameter logic [15:0] MIN_FRAME = 16'd38
) (
  input  logic                     clk156,
  input  logic                     sys_rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*16-1:0]       frame_len,
  output logic [NREQ-1:0]          gnt,
  output logic [159:0]             hdr,
  output logic [$clog2(NREQ)-1:0]  hdr_src,
  output logic                     hdr_valid,
  input  logic                     hdr_ready,
  output logic                     len_err,
  output logic [31:0]              hdr_cnt
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, SUM, FOLD, OUT} state_t;

  typedef struct packed {
    logic [3:0]  ver;
    logic [3:0]  ihl;
    logic [7:0]  tos;
    logic [15:0] tot_len;
    logic [15:0] id;
    logic [15:0] frag_off;
    logic [7:0]  ttl;
    logic [7:0]  proto;
    logic [15:0] check;
    logic [31:0] saddr;
    logic [31:0] daddr;
  } ip_hdr_t;

  function automatic ip_hdr_t mk_hdr(input logic [15:0] tot, input logic [15:0] id,
                                     input logic [15:0] chk);
    ip_hdr_t h;
    h.ver      = 4'd4;
    h.ihl      = 4'd5;
    h.tos      = 8'h00;
    h.tot_len  = tot;
    h.id       = id;
    h.frag_off = 16'h0000;
    h.ttl      = 8'd64;
    h.proto    = 8'h11;
    h.check    = chk;
    h.saddr    = SADDR;
    h.daddr    = DADDR;
    return h;
  endfunction

  logic [NREQ-1:0]        lane_short;
  logic [NREQ-1:0][15:0]  lane_tot;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    ip_hdr_sched_lane #(.MIN_FRAME(MIN_FRAME)) u_lane (
      .frame_len (frame_len[16*i +: 16]),
      .short_len (lane_short[i]),
      .tot_len   (lane_tot[i])
    );
  end

  state_t         state;
  logic [IW-1:0]  ptr;
  logic [IW-1:0]  lane_lat;
  logic [15:0]    tot_lat;
  logic [15:0]    id_cnt;
  logic [3:0]     wcnt;
  logic [23:0]    acc;
  logic [159:0]   shreg;

  // Round-robin search starting just after the last granted lane.
  logic [IW-1:0]  sel;
  logic           any;
  int             idx;
  always_comb begin
    sel = '0;
    any = 1'b0;
    idx = 0;
    for (int o = 1; o <= NREQ; o++) begin
      idx = (int'(ptr) + o) % NREQ;
      if (!any && req[idx]) begin
        any = 1'b1;
        sel = IW'(idx);
      end
    end
  end

  // Grant is visible in the same IDLE cycle the request is seen.
  always_comb begin
    gnt = '0;
    if (state == IDLE && !sys_rst && any) gnt[sel] = 1'b1;
  end

  logic [16:0] fold_t;
  logic [15:0] fold_c;
  logic [15:0] check;
  assign fold_t = {1'b0, acc[15:0]} + {9'd0, acc[23:16]};
  assign fold_c = fold_t[15:0] + {15'd0, fold_t[16]};
  assign check  = ~fold_c;

  always_ff @(posedge clk156) begin
    if (sys_rst) begin
      state     <= IDLE;
      ptr       <= IW'(NREQ - 1);
      lane_lat  <= '0;
      tot_lat   <= '0;
      id_cnt    <= '0;
      wcnt      <= '0;
      acc       <= '0;
      shreg     <= '0;
      hdr       <= '0;
      hdr_src   <= '0;
      hdr_valid <= 1'b0;
      len_err   <= 1'b0;
      hdr_cnt   <= '0;
    end else begin
      len_err <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            ptr      <= sel;
            lane_lat <= sel;
            tot_lat  <= lane_tot[sel];
            if (lane_short[sel]) begin
              len_err <= 1'b1;
            end else begin
              state <= SUM;
              wcnt  <= '0;
              acc   <= '0;
              shreg <= mk_hdr(lane_tot[sel], id_cnt, 16'h0000);
            end
          end
        end
        SUM: begin
          // Header words leave MSB-first so word k is always at the top.
          acc   <= acc + {8'd0, shreg[159:144]};
          shreg <= shreg << 16;
          wcnt  <= wcnt + 4'd1;
          if (wcnt == 4'd9) state <= FOLD;
        end
        FOLD: begin
          hdr       <= mk_hdr(tot_lat, id_cnt, check);
          hdr_src   <= lane_lat;
          hdr_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (hdr_ready) begin
            hdr_valid <= 1'b0;
            hdr_cnt   <= hdr_cnt + 32'd1;
            id_cnt    <= id_cnt + 16'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ip_hdr_sched.md
Name: ip_hdr_sched

Overview:
- Shares one serial IPv4 header/checksum engine among N packet-generator lanes on the 10G datapath.
- Arbitrates lane requests round-robin and builds a 20-byte UDP/IPv4 header from each lane's frame length and a global ID counter.
- Computes the header checksum one 16-bit word per cycle and presents the finished header to the frame assembler with a valid/ready handshake.

Parameters:
- NREQ, 4, number of requesting lanes (2..8)
- SADDR, 32'hC0A80165, source address 192.168.1.101
- DADDR, 32'hC0A80266, destination address 192.168.2.102
- MIN_FRAME, 16'd38, smallest legal frame_len: Ethernet header 14 + FCS 4 + IP header 20

Ports:
- clk156  in  1  datapath clock
- sys_rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-lane request, level; held until gnt
- frame_len  in  NREQ*16  lane i length at [16i+15:16i]; full frame incl. Ethernet header and FCS; stable while req[i]=1
- gnt  out  NREQ  one-cycle one-hot grant
- hdr  out  160  IP header, packed version first, check and addresses in network order
- hdr_src  out  clog2(NREQ)  lane index that owns hdr
- hdr_valid  out  1  hdr holds a complete header
- hdr_ready  in  1  consumer accepts when hdr_valid && hdr_ready
- len_err  out  1  one-cycle pulse: granted request rejected
- hdr_cnt  out  32  headers accepted since reset, wraps

Behaviour:
- Reset: state=IDLE; gnt=0, hdr=0, hdr_src=0, hdr_valid=0, len_err=0, hdr_cnt=0; ID counter=0; round-robin pointer=NREQ-1, so lane 0 has first priority.
- States: IDLE, SUM, FOLD, OUT.
- IDLE:
  - If any req is set, grant the first set lane searching from pointer+1 modulo NREQ. That cycle: gnt[i]=1, latch frame_len[i] and lane index, pointer<=i.
  - If latched frame_len < MIN_FRAME: pulse len_err next cycle, stay in IDLE, ID not incremented, no header. Lane pointer still advances.
  - Otherwise go to SUM.
- Header fields:
  - version=4, ihl=5, tos=0
  - tot_len = frame_len - 18, 16-bit
  - id = ID counter
  - frag_off=0, ttl=64, protocol=8'h11, check=0 during summing
  - saddr=SADDR, daddr=DADDR
- SUM:
  - Exactly 10 cycles. A word counter 0..9 adds header word k (16-bit, big-endian, check word = 0) into a 24-bit accumulator cleared on entry.
  - Go to FOLD after k=9.
- FOLD (1 cycle):
  - t = sum[15:0] + sum[23:16] (17-bit); c = t[15:0] + t[16]; check = ~c[15:0].
  - Load hdr with check inserted, hdr_src = latched lane, then go to OUT.
- OUT:
  - hdr_valid=1; hdr and hdr_src held stable.
  - On hdr_valid && hdr_ready: hdr_valid<=0, hdr_cnt+1, ID counter+1 (16-bit wrap FFFF->0000), return to IDLE.
- Latency: grant cycle G, hdr_valid first high at G+12. Minimum spacing between grants is 13 cycles with hdr_ready tied high.
- No new grant outside IDLE. req changes outside IDLE are ignored.
- A lane whose req drops before gnt is simply skipped.
- sys_rst mid-operation: abort immediately to reset values. Any in-flight header is discarded without a handshake.
- A req asserted in the same cycle as the return to IDLE is serviced on the following IDLE cycle.

Test Plan:
- Lane 0, frame_len=64, first header -> gnt[0] at G; at G+12 hdr_valid=1, tot_len=16'h002E, id=0, check=16'hF5A3, hdr_src=0; with ready, hdr_cnt=1.
- Repeat lane 0, frame_len=64 -> id=1, check=16'hF5A2.
- req=4'b1111 held continuously, hdr_ready=1 -> grant order 0,1,2,3,0; hdr_src sequence identical; ids 0..4.
- Lane 2, frame_len=30 -> gnt[2], len_err pulse one cycle later, no hdr_valid; next legal header still uses id=0; hdr_cnt unchanged.
- hdr_ready low for 20 cycles in OUT -> hdr_valid and hdr stay constant and no grants occur; the cycle after ready rises, state is IDLE and the next grant follows.
- Assert sys_rst during SUM (k=5) -> next cycle all outputs are at reset values; a new lane-0 request then yields id=0, check=16'hF5A3.
